// File: rtl/interrupt_controller.sv
// Edge-triggered interrupt controller: pending/enable registers, lowest-index-wins
// arbitration and an IDLE/REQ/SERVICE handshake with the CPU (ack, then eoi).
module interrupt_controller #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] src,
    input  logic               en_we,
    input  logic [NUM_SRC-1:0] en_wdata,
    input  logic               irq_ack,
    input  logic               irq_eoi,
    output logic               irq_req,
    output logic [ID_W-1:0]    irq_id,
    output logic               in_service,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] enable
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] src_prev_q, src_prev_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic               irq_req_q, irq_req_d;
    logic [ID_W-1:0]    irq_id_q, irq_id_d;
    logic               in_service_q, in_service_d;

    logic [NUM_SRC-1:0] edges;
    logic [NUM_SRC-1:0] candidates;
    logic [NUM_SRC-1:0] clr_mask;
    logic [ID_W-1:0]    winner;
    logic               accept;

    always_comb begin
        edges      = src & ~src_prev_q;
        candidates = pending_q & enable_q;
        accept     = (state_q == REQ) && irq_ack;

        // Descending scan so the lowest set index is the last to be written.
        winner = '0;
        for (int unsigned i = NUM_SRC; i > 0; i--) begin
            if (candidates[i-1]) begin
                winner = ID_W'(i - 1);
            end
        end

        clr_mask = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            clr_mask[i] = accept && (irq_id_q == ID_W'(i));
        end

        src_prev_d = src;
        // A new edge on the source being acknowledged overrides the clear.
        pending_d  = (pending_q & ~clr_mask) | edges;
        enable_d   = en_we ? en_wdata : enable_q;
    end

    always_comb begin
        state_d      = state_q;
        irq_req_d    = irq_req_q;
        irq_id_d     = irq_id_q;
        in_service_d = in_service_q;
        case (state_q)
            IDLE: begin
                if (candidates != '0) begin
                    state_d      = REQ;
                    irq_req_d    = 1'b1;
                    irq_id_d     = winner;
                    in_service_d = 1'b0;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_d      = SERVICE;
                    irq_req_d    = 1'b0;
                    in_service_d = 1'b1;
                end
            end
            SERVICE: begin
                if (irq_eoi) begin
                    state_d      = IDLE;
                    in_service_d = 1'b0;
                end
            end
            default: begin
                state_d      = IDLE;
                irq_req_d    = 1'b0;
                in_service_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            src_prev_q   <= '0;
            pending_q    <= '0;
            enable_q     <= '0;
            irq_req_q    <= 1'b0;
            irq_id_q     <= '0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_prev_q   <= src_prev_d;
            pending_q    <= pending_d;
            enable_q     <= enable_d;
            irq_req_q    <= irq_req_d;
            irq_id_q     <= irq_id_d;
            in_service_q <= in_service_d;
        end
    end

    assign irq_req    = irq_req_q;
    assign irq_id     = irq_id_q;
    assign in_service = in_service_q;
    assign pending    = pending_q;
    assign enable     = enable_q;

endmodule
